// File: rtl/blast_clearer.sv
// blast_clearer: walks the four blast arms of a detonating bomb,
// emitting flame events and clearing the first brick hit on each arm.
module blast_clearer #(
    parameter int NUM_ROW       = 11,
    parameter int NUM_COL       = 13,
    parameter int MAP_MEM_WIDTH = 2,
    parameter logic [MAP_MEM_WIDTH-1:0] TILE_FREE  = MAP_MEM_WIDTH'(0),
    parameter logic [MAP_MEM_WIDTH-1:0] TILE_WALL  = MAP_MEM_WIDTH'(1),
    parameter logic [MAP_MEM_WIDTH-1:0] TILE_BRICK = MAP_MEM_WIDTH'(2),
    localparam int ADDR_WIDTH = $clog2(NUM_ROW * NUM_COL),
    localparam int RW         = $clog2(NUM_ROW),
    localparam int CW         = $clog2(NUM_COL)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     game_over,
    input  logic                     start,
    input  logic [RW-1:0]            bomb_row,
    input  logic [CW-1:0]            bomb_col,
    input  logic [1:0]               bomb_range,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [MAP_MEM_WIDTH-1:0] rd_data,
    output logic                     we_out,
    output logic [ADDR_WIDTH-1:0]    write_addr_out,
    output logic [MAP_MEM_WIDTH-1:0] write_data_out,
    output logic                     flame_valid,
    output logic [ADDR_WIDTH-1:0]    flame_addr,
    output logic                     busy,
    output logic                     done
);

    localparam int RS = RW + 2;
    localparam int CS = CW + 2;
    localparam logic signed [RS-1:0] ROW_LIM = RS'(NUM_ROW);
    localparam logic signed [CS-1:0] COL_LIM = CS'(NUM_COL);
    localparam logic [ADDR_WIDTH-1:0] NCOL_A = ADDR_WIDTH'(NUM_COL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_EVAL,
        S_CLEAR,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    state_t                  state_q;
    logic [RW-1:0]           row_q;
    logic [CW-1:0]           col_q;
    logic [1:0]              range_q;
    logic [1:0]              dir_q;
    logic [1:0]              step_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic                    we_q;
    logic                    busy_q;
    logic                    done_q;

    logic signed [RS-1:0]    cand_row;
    logic signed [CS-1:0]    cand_col;
    logic                    cand_oob;
    logic [ADDR_WIDTH-1:0]   cand_addr;

    // Candidate tile one step along the current arm, widened so edges never wrap
    always_comb begin
        cand_row = $signed({2'b00, row_q});
        cand_col = $signed({2'b00, col_q});
        case (dir_q)
            D_UP:    cand_row = cand_row - $signed(RS'(step_q));
            D_DOWN:  cand_row = cand_row + $signed(RS'(step_q));
            D_LEFT:  cand_col = cand_col - $signed(CS'(step_q));
            default: cand_col = cand_col + $signed(CS'(step_q));
        endcase
        cand_oob = cand_row[RS-1] || (cand_row >= ROW_LIM) ||
                   cand_col[CS-1] || (cand_col >= COL_LIM);
        cand_addr = ADDR_WIDTH'(cand_row[RW-1:0]) * NCOL_A +
                    ADDR_WIDTH'(cand_col[CW-1:0]);
    end

    // Scan sequencer with registered strobes aligned to their states
    always_ff @(posedge clk) begin
        if (rst || game_over) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            range_q   <= '0;
            dir_q     <= D_UP;
            step_q    <= 2'd1;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q   <= bomb_row;
                        col_q   <= bomb_col;
                        range_q <= bomb_range;
                        dir_q   <= D_UP;
                        step_q  <= 2'd1;
                        if (bomb_range == 2'd0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_CHECK;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (cand_oob) begin
                        state_q <= S_NEXT;
                    end else begin
                        rd_addr_q <= cand_addr;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: state_q <= S_EVAL;
                S_EVAL: begin
                    if (rd_data == TILE_WALL) begin
                        state_q <= S_NEXT;
                    end else if (rd_data == TILE_BRICK) begin
                        we_q      <= 1'b1;
                        wr_addr_q <= rd_addr_q;
                        state_q   <= S_CLEAR;
                    end else if (step_q == range_q) begin
                        state_q <= S_NEXT;
                    end else begin
                        step_q  <= step_q + 2'd1;
                        state_q <= S_CHECK;
                    end
                end
                S_CLEAR: state_q <= S_NEXT;
                S_NEXT: begin
                    step_q <= 2'd1;
                    if (dir_q == D_RIGHT) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        dir_q   <= dir_q + 2'd1;
                        state_q <= S_CHECK;
                    end
                end
                S_FINISH: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr        = rd_addr_q;
    assign we_out         = we_q;
    assign write_addr_out = wr_addr_q;
    assign write_data_out = TILE_FREE;
    assign flame_valid    = (state_q == S_EVAL) && (rd_data != TILE_WALL);
    assign flame_addr     = rd_addr_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_blast_clearer.sv
// tb_blast_clearer: directed scans on an 11x13 map with a
// registered map-memory model and hand-computed event lists.
module tb_blast_clearer;

    localparam int NTILE = 143;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_over = 1'b0;
    logic       start = 1'b0;
    logic [3:0] bomb_row = '0;
    logic [3:0] bomb_col = '0;
    logic [1:0] bomb_range = '0;
    logic [7:0] rd_addr;
    logic [1:0] rd_data = '0;
    logic       we_out;
    logic [7:0] write_addr_out;
    logic [1:0] write_data_out;
    logic       flame_valid;
    logic [7:0] flame_addr;
    logic       busy;
    logic       done;

    blast_clearer dut (
        .clk(clk), .rst(rst), .game_over(game_over), .start(start),
        .bomb_row(bomb_row), .bomb_col(bomb_col), .bomb_range(bomb_range),
        .rd_addr(rd_addr), .rd_data(rd_data), .we_out(we_out),
        .write_addr_out(write_addr_out), .write_data_out(write_data_out),
        .flame_valid(flame_valid), .flame_addr(flame_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [0:NTILE-1];
    logic [7:0] fl_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] prev_rd;
    int         done_cnt, both_cnt, bad_wd;
    int         err_cnt = 0, chk_cnt = 0;
    int         cyc, busy1, busy_done, done_after;

    always @(posedge clk) begin
        rd_data <= (rd_addr < NTILE) ? mem[rd_addr] : 2'd3;
        if (we_out && write_addr_out < NTILE) mem[write_addr_out] <= write_data_out;
    end

    always @(negedge clk) begin
        if (flame_valid) fl_q.push_back(flame_addr);
        if (we_out) begin
            wr_q.push_back(write_addr_out);
            if (write_data_out != 2'd0) bad_wd++;
        end
        if (we_out && flame_valid) both_cnt++;
        if (done) done_cnt++;
        if (rd_addr != prev_rd) begin
            rd_q.push_back(rd_addr);
            prev_rd = rd_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] a(input int r, input int c);
        return 8'(r * 13 + c);
    endfunction

    function automatic bit was_read(input logic [7:0] ad);
        foreach (rd_q[i]) if (rd_q[i] == ad) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic map_clear();
        for (int i = 0; i < NTILE; i++) mem[i] = 2'd0;
    endtask

    task automatic clear_logs();
        fl_q.delete();
        wr_q.delete();
        rd_q.delete();
        prev_rd = rd_addr;
        done_cnt = 0;
        both_cnt = 0;
        bad_wd = 0;
    endtask

    task automatic run_scan(input int r, input int c, input int rg, input int restart);
        clear_logs();
        bomb_row = 4'(r);
        bomb_col = 4'(c);
        bomb_range = 2'(rg);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy1 = busy;
        for (int i = 1; i <= 200; i++) begin
            if (done) begin
                cyc = i;
                busy_done = busy;
                break;
            end
            if (i == restart) begin
                start = 1'b1;
                bomb_row = 4'd0;
                bomb_col = 4'd0;
                bomb_range = 2'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc == 0) check("done_timeout", 0, 1);
        @(negedge clk);
        done_after = done;
    endtask

    initial begin
        map_clear();
        clear_logs();
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", we_out, 0);
        check("rst_flame", flame_valid, 0);
        check("rst_addrs", {rd_addr, write_addr_out, flame_addr}, 0);
        check("rst_wdata", write_data_out, 0);

        // range 1 open field
        run_scan(5, 5, 1, 0);
        check("t1_cyc", cyc, 17);
        check("t1_busy1", busy1, 1);
        check("t1_busy_done", busy_done, 0);
        check("t1_pulse", done_after, 0);
        check("t1_nfl", fl_q.size(), 4);
        if (fl_q.size() == 4)
            check("t1_fl", {fl_q[0], fl_q[1], fl_q[2], fl_q[3]},
                  {a(4,5), a(6,5), a(5,4), a(5,6)});
        check("t1_nwr", wr_q.size(), 0);

        // brick chain upward
        do_reset();
        map_clear();
        mem[a(3,5)] = 2'd2;
        mem[a(2,5)] = 2'd2;
        run_scan(5, 5, 3, 0);
        check("t2_cyc", cyc, 39);
        check("t2_nfl", fl_q.size(), 11);
        if (fl_q.size() >= 2)
            check("t2_fl_up", {fl_q[0], fl_q[1]}, {a(4,5), a(3,5)});
        check("t2_nwr", wr_q.size(), 1);
        if (wr_q.size() == 1) check("t2_wr", wr_q[0], a(3,5));
        check("t2_wdata", bad_wd, 0);
        check("t2_noread", was_read(a(2,5)), 0);
        check("t2_nrd", rd_q.size(), 11);
        check("t2_mem", mem[a(3,5)], 0);
        check("t2_excl", both_cnt, 0);

        // wall on the right arm
        do_reset();
        map_clear();
        mem[a(5,6)] = 2'd1;
        run_scan(5, 5, 2, 0);
        check("t3_cyc", cyc, 26);
        check("t3_nfl", fl_q.size(), 6);
        if (fl_q.size() == 6) check("t3_last", fl_q[5], a(5,4) - 8'd1);
        check("t3_noread", was_read(a(5,7)), 0);
        check("t3_nrd", rd_q.size(), 7);
        check("t3_nwr", wr_q.size(), 0);

        // top-left corner
        do_reset();
        map_clear();
        run_scan(0, 0, 2, 0);
        check("t4_cyc", cyc, 19);
        check("t4_nrd", rd_q.size(), 4);
        check("t4_nfl", fl_q.size(), 4);
        if (fl_q.size() == 4)
            check("t4_fl", {fl_q[0], fl_q[1], fl_q[2], fl_q[3]},
                  {a(1,0), a(2,0), a(0,1), a(0,2)});
        if (rd_q.size() == 4)
            check("t4_rd", {rd_q[0], rd_q[1], rd_q[2], rd_q[3]},
                  {a(1,0), a(2,0), a(0,1), a(0,2)});

        // bottom-right corner
        do_reset();
        run_scan(10, 12, 1, 0);
        check("t5_cyc", cyc, 13);
        check("t5_nfl", fl_q.size(), 2);
        if (fl_q.size() == 2)
            check("t5_fl", {fl_q[0], fl_q[1]}, {a(9,12), a(10,11)});

        // range 0
        do_reset();
        run_scan(5, 5, 0, 0);
        check("t6_cyc", cyc, 1);
        check("t6_busy_done", busy_done, 0);
        check("t6_events", fl_q.size() + wr_q.size() + rd_q.size(), 0);

        // restart request while busy is ignored
        do_reset();
        run_scan(5, 5, 1, 5);
        check("t7_cyc", cyc, 17);
        check("t7_ndone", done_cnt, 1);
        check("t7_nfl", fl_q.size(), 4);
        if (fl_q.size() == 4)
            check("t7_fl", {fl_q[0], fl_q[1], fl_q[2], fl_q[3]},
                  {a(4,5), a(6,5), a(5,4), a(5,6)});

        // abort during brick evaluation
        do_reset();
        map_clear();
        mem[a(4,5)] = 2'd2;
        clear_logs();
        bomb_row = 4'd5;
        bomb_col = 4'd5;
        bomb_range = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t8_eval_flame", {flame_valid, flame_addr}, {1'b1, a(4,5)});
        game_over = 1'b1;
        @(negedge clk);
        check("t8_abort", {busy, we_out, done}, 0);
        game_over = 1'b0;
        repeat (6) @(negedge clk);
        check("t8_nwr", wr_q.size(), 0);
        check("t8_ndone", done_cnt, 0);
        check("t8_mem", mem[a(4,5)], 2);
        run_scan(5, 5, 1, 0);
        check("t8_cyc", cyc, 18);
        check("t8_nfl", fl_q.size(), 4);
        check("t8_nwr2", wr_q.size(), 1);
        if (wr_q.size() == 1) check("t8_wr", wr_q[0], a(4,5));
        check("t8_mem2", mem[a(4,5)], 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
